// File: rtl/axis_log_packager.sv
`default_nettype none
// ============================================================================
// Module      : axis_log_packager
// Description : Buffers logged flits from the governor log port in a FIFO and
//               re-emits each one as a two-beat AXI-Stream packet: a header
//               beat {zeros, seq, TDEST}, then the data beat carrying TLAST.
//               in_TREADY is a pure register output, so the upstream
//               log_TVALID may legally depend on it.
// Ports       : clk, rst_n                   clock, async active-low reset
//               in_TDATA/TDEST/TVALID/TREADY  logged-flit input stream
//               out_TDATA/TVALID/TREADY/TLAST packet output stream
//               level                         FIFO occupancy 0..2**ADDR_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module axis_log_packager #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int SEQ_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic [DEST_WIDTH-1:0] in_TDEST,
    input  logic                  in_TVALID,
    output logic                  in_TREADY,
    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic                  out_TVALID,
    input  logic                  out_TREADY,
    output logic                  out_TLAST,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int                c_DEPTH_INT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = c_DEPTH_INT[ADDR_WIDTH:0];
    localparam int                c_ENTRY_W   = DEST_WIDTH + DATA_WIDTH;

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    // Storage and state
    logic [c_ENTRY_W-1:0]  r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  r_in_ready;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_valid;
    logic                  w_out_hs;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [c_ENTRY_W-1:0]  w_head;
    logic [DEST_WIDTH-1:0] w_head_dest;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DATA_WIDTH-1:0] w_hdr;

    // Valid is driven purely from the occupancy register, never from
    // out_TREADY, so the output stream has no ready->valid path.
    assign w_out_valid  = (r_count != '0);
    assign w_out_hs     = w_out_valid && out_TREADY;
    assign w_push       = in_TVALID && r_in_ready;
    assign w_pop        = (r_state == S_DATA) && w_out_hs;
    assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_push}
                                  - {{ADDR_WIDTH{1'b0}}, w_pop};

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_dest = w_head[c_ENTRY_W-1:DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    // FIFO storage: no reset needed, occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_TDEST, in_TDATA};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            // Look-ahead on the next occupancy keeps in_TREADY registered
            // while still never letting a push land on a full FIFO.
            r_in_ready <= (w_count_next != c_DEPTH);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_seq    <= r_seq + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: HDR only leaves on a real handshake, which requires a
    // non-empty FIFO, so DATA is never entered with count == 0.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_out_hs) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_out_hs) begin
                    w_state_next = S_HDR;
                end
            end
            default: w_state_next = S_HDR;
        endcase
    end

    // Header: sequence number above TDEST, upper bits zero-filled.
    always_comb begin
        w_hdr = '0;
        w_hdr[SEQ_WIDTH+DEST_WIDTH-1:0] = {r_seq, w_head_dest};
    end

    assign out_TDATA  = (r_state == S_DATA) ? w_head_data : w_hdr;
    assign out_TLAST  = (r_state == S_DATA);
    assign out_TVALID = w_out_valid;
    assign in_TREADY  = r_in_ready;
    assign level      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_log_packager.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_log_packager
// Description : Self-checking bench for axis_log_packager. A queue-based
//               packet model predicts every output; a vector table covers
//               the single-flit packet, hand sequences cover full FIFO,
//               simultaneous push/pop, mid-packet reset and seq wrap on a
//               4-bit-sequence instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_log_packager;

    typedef struct packed {
        logic [15:0] dest;
        logic [63:0] data;
    } flit_t;

    typedef struct {
        bit          offer;
        logic [63:0] data;
        logic [15:0] dest;
        bit          ordy;
        bit          e_valid;
        logic [63:0] e_data;
        bit          e_last;
        int          e_level;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_TDATA;
    logic [15:0] in_TDEST;
    logic        in_TVALID;
    logic        in_TREADY;
    logic [63:0] out_TDATA;
    logic        out_TVALID;
    logic        out_TREADY;
    logic        out_TLAST;
    logic [4:0]  level;

    logic [63:0] d4_in_TDATA;
    logic [15:0] d4_in_TDEST;
    logic        d4_in_TVALID;
    logic        d4_in_TREADY;
    logic [63:0] d4_out_TDATA;
    logic        d4_out_TVALID;
    logic        d4_out_TREADY;
    logic        d4_out_TLAST;
    logic [4:0]  d4_level;

    axis_log_packager #(
        .DATA_WIDTH(64), .DEST_WIDTH(16), .ADDR_WIDTH(4), .SEQ_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_TDATA(in_TDATA), .in_TDEST(in_TDEST),
        .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA), .out_TVALID(out_TVALID),
        .out_TREADY(out_TREADY), .out_TLAST(out_TLAST),
        .level(level)
    );

    axis_log_packager #(
        .DATA_WIDTH(64), .DEST_WIDTH(16), .ADDR_WIDTH(4), .SEQ_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_TDATA(d4_in_TDATA), .in_TDEST(d4_in_TDEST),
        .in_TVALID(d4_in_TVALID), .in_TREADY(d4_in_TREADY),
        .out_TDATA(d4_out_TDATA), .out_TVALID(d4_out_TVALID),
        .out_TREADY(d4_out_TREADY), .out_TLAST(d4_out_TLAST),
        .level(d4_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    flit_t       q[$];
    int unsigned m_seq   = 0;
    bit          m_data_phase = 0;
    bit          m_ready = 0;
    bit          acc = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e;
        check("in_TREADY", 64'(in_TREADY), 64'(m_ready));
        check("out_TVALID", 64'(out_TVALID), 64'(q.size() != 0));
        check("level", 64'(level), 64'(q.size()));
        if (q.size() != 0) begin
            e = m_data_phase ? q[0].data : {16'h0, m_seq, q[0].dest};
            check("out_TDATA", out_TDATA, e);
            check("out_TLAST", 64'(out_TLAST), 64'(m_data_phase));
        end
    endtask

    // One clock cycle: check at the falling edge, drive inputs, then apply
    // the packet rules for the rising edge to the model.
    task automatic step(input bit offer, input bit ordy, input bit fixed,
                        input logic [63:0] fd, input logic [15:0] fde);
        bit push;
        bit hs;
        @(negedge clk);
        check_outputs();
        if (prev_stall) begin
            check("stall_hold_TDATA", out_TDATA, prev_data);
            check("stall_hold_TLAST", 64'(out_TLAST), 64'(prev_last));
        end
        if (acc || !in_TVALID) begin
            in_TVALID = offer;
            in_TDATA  = fixed ? fd  : {$urandom, $urandom};
            in_TDEST  = fixed ? fde : 16'($urandom);
        end
        acc        = 0;
        out_TREADY = ordy;
        push       = in_TVALID && m_ready;
        hs         = out_TREADY && (q.size() != 0);
        prev_stall = (q.size() != 0) && !out_TREADY;
        prev_data  = out_TDATA;
        prev_last  = out_TLAST;
        @(posedge clk);
        if (hs) begin
            if (!m_data_phase) begin
                m_data_phase = 1;
            end else begin
                void'(q.pop_front());
                m_seq++;
                m_data_phase = 0;
            end
        end
        if (push) begin
            q.push_back('{dest: in_TDEST, data: in_TDATA});
            acc = 1;
        end
        m_ready = (q.size() != 16);
    endtask

    // Asserts reset off the clock edge, checks the asynchronous clear, then
    // releases on a falling edge so the first rising edge raises in_TREADY.
    task automatic do_reset();
        #2;
        rst_n         = 1'b0;
        in_TVALID     = 1'b0;
        out_TREADY    = 1'b0;
        d4_in_TVALID  = 1'b0;
        #1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_out_TVALID", 64'(out_TVALID), 64'd0);
        check("rst_out_TLAST", 64'(out_TLAST), 64'd0);
        check("rst_in_TREADY", 64'(in_TREADY), 64'd0);
        q.delete();
        m_seq = 0; m_data_phase = 0; m_ready = 0; acc = 0; prev_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_TREADY_before_edge", 64'(in_TREADY), 64'd0);
        @(posedge clk);
        #1;
        m_ready = 1;
        check_outputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || in_TVALID) && n < budget) begin
            step(0, 1, 0, 64'd0, 16'd0);
            n++;
        end
        n_tests++;
        if (q.size() != 0 || in_TVALID) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d flits left, required 0", q.size());
        end
    endtask

    // 20 flits through the 4-bit-sequence instance; headers must carry
    // seq = flit index mod 16.
    task automatic run_seq4();
        logic [63:0] fdat [20];
        logic [15:0] fdst [20];
        logic [63:0] e;
        int i = 0;
        int nb = 0;
        int k;
        bit taken = 0;
        for (int j = 0; j < 20; j++) begin
            fdat[j] = {$urandom, $urandom};
            fdst[j] = 16'($urandom);
        end
        d4_out_TREADY = 1'b1;
        for (int cyc = 0; cyc < 400 && nb < 40; cyc++) begin
            @(negedge clk);
            if (taken) i++;
            if (d4_out_TVALID) begin
                k = nb / 2;
                if ((nb % 2) == 0) begin
                    e = 64'(k % 16) << 16 | 64'(fdst[k]);
                    check("seq4_hdr", d4_out_TDATA, e);
                    check("seq4_hdr_last", 64'(d4_out_TLAST), 64'd0);
                end else begin
                    check("seq4_data", d4_out_TDATA, fdat[k]);
                    check("seq4_data_last", 64'(d4_out_TLAST), 64'd1);
                end
                nb++;
            end
            d4_in_TVALID = (i < 20);
            d4_in_TDATA  = (i < 20) ? fdat[i] : 64'd0;
            d4_in_TDEST  = (i < 20) ? fdst[i] : 16'd0;
            taken        = d4_in_TVALID && d4_in_TREADY;
        end
        @(negedge clk);
        d4_in_TVALID = 1'b0;
        check("seq4_beat_count", 64'(nb), 64'd40);
    endtask

    vec_t tbl[4];

    initial begin
        rst_n = 1'b0;
        in_TVALID = 1'b0; in_TDATA = '0; in_TDEST = '0; out_TREADY = 1'b0;
        d4_in_TVALID = 1'b0; d4_in_TDATA = '0; d4_in_TDEST = '0; d4_out_TREADY = 1'b0;

        // Single-flit packet; expectations are outputs just after each edge.
        tbl[0] = '{1, 64'hDEAD_BEEF_0000_0001, 16'h0005, 1, 1, 64'h0000_0000_0000_0005, 0, 1};
        tbl[1] = '{0, 64'h0, 16'h0, 1, 1, 64'hDEAD_BEEF_0000_0001, 1, 1};
        tbl[2] = '{0, 64'h0, 16'h0, 1, 0, 64'h0, 0, 0};
        tbl[3] = '{0, 64'h0, 16'h0, 1, 0, 64'h0, 0, 0};

        // Reset release and idle
        do_reset();
        for (int c = 0; c < 3; c++) step(0, 0, 0, 64'd0, 16'd0);

        // Table: single flit
        for (int r = 0; r < 4; r++) begin
            step(tbl[r].offer, tbl[r].ordy, 1, tbl[r].data, tbl[r].dest);
            #1;
            check("tbl_valid", 64'(out_TVALID), 64'(tbl[r].e_valid));
            check("tbl_level", 64'(level), 64'(tbl[r].e_level));
            check("tbl_last", 64'(out_TLAST), 64'(tbl[r].e_last));
            if (tbl[r].e_valid) check("tbl_data", out_TDATA, tbl[r].e_data);
        end

        // Fill to full with output stalled, 17th flit must be held
        do_reset();
        for (int c = 0; c < 17; c++) step(1, 0, 0, 64'd0, 16'd0);
        #1;
        check("full_level", 64'(level), 64'd16);
        check("full_in_TREADY", 64'(in_TREADY), 64'd0);
        for (int c = 0; c < 3; c++) step(1, 0, 0, 64'd0, 16'd0);
        drain(100);

        // Random input offers and output stalls
        for (int c = 0; c < 300; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 64'd0, 16'd0);
        drain(100);

        // Simultaneous push and pop at level 3
        do_reset();
        for (int c = 0; c < 3; c++) step(1, 0, 0, 64'd0, 16'd0);
        step(0, 1, 0, 64'd0, 16'd0);
        step(1, 1, 0, 64'd0, 16'd0);
        #1;
        check("pushpop_level", 64'(level), 64'd3);
        drain(50);

        // Reset mid-packet: DATA phase with level 5
        do_reset();
        for (int c = 0; c < 5; c++) step(1, 0, 0, 64'd0, 16'd0);
        step(0, 1, 0, 64'd0, 16'd0);
        #1;
        check("mid_level", 64'(level), 64'd5);
        check("mid_in_data", 64'(out_TLAST), 64'd1);
        do_reset();
        step(1, 0, 0, 64'd0, 16'd0);
        #1;
        check("post_rst_seq", 64'(out_TDATA[47:16]), 64'd0);
        check("post_rst_last", 64'(out_TLAST), 64'd0);
        drain(50);

        // Sequence wrap on the 4-bit-sequence instance
        do_reset();
        run_seq4();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
